// File: rtl/gpio_int_pkg.sv
// Shared types and constants for the GPIO interrupt acknowledge controller:
// acknowledge FSM states, register map and bus read latency.
package gpio_int_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACK   = 2'd1;
    localparam logic [1:0] ST_RECOV = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ACK   = ST_ACK,
        RECOV = ST_RECOV
    } ack_st_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CODE   = 2'd2;
    localparam logic [1:0] ADDR_SPUR   = 2'd3;

    // Cycles from csn fall to the rd_valid strobe
    localparam int RD_LAT = 7;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/gpio_int_ack_ctrl_if.sv
// Software data bus (csn/wr/rd strobes) used to drain captured interrupt codes.
// The master drives strobes, address and write data; the slave returns data and strobes.
interface gpio_int_ack_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              i_csn_50m;
    logic              i_wr_50m;
    logic              i_rd_50m;
    logic [1:0]        i_addr_50m;
    logic [DATA_W-1:0] i_datin_50m;
    logic [DATA_W-1:0] o_datout_50m;
    logic              wr_valid;
    logic              rd_valid;

    modport master (
        output i_csn_50m, i_wr_50m, i_rd_50m, i_addr_50m, i_datin_50m,
        input  o_datout_50m, wr_valid, rd_valid
    );

    modport slave (
        input  i_csn_50m, i_wr_50m, i_rd_50m, i_addr_50m, i_datin_50m,
        output o_datout_50m, wr_valid, rd_valid
    );
endinterface

// File: rtl/gpio_int_code_fifo.sv
// Small synchronous FIFO holding captured {valid, code} words; show-ahead head,
// flush overrides same-cycle push and pop, count never wraps.
module gpio_int_code_fifo #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;
    assign count   = count_reg;
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/gpio_int_ack_ctrl.sv
// Consumer of the GPIO interrupt controller: runs the INTA_N handshake, queues
// captured codes and exposes them to software over the csn/wr/rd data bus.
module gpio_int_ack_ctrl
    import gpio_int_pkg::*;
#(
    parameter int CODE_W   = 3,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int INTA_LEN = 2,
    parameter int GAP      = 2
) (
    input  logic              clk_50m,
    input  logic              rstn_50m,
    input  logic              INTR,
    input  logic [CODE_W-1:0] INT_CODE,
    output logic              INTA_N,
    gpio_int_ack_ctrl_if.slave bus,
    output logic              o_irq_cpu
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int LEN_W = (INTA_LEN > 1) ? $clog2(INTA_LEN) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    // Bus front end
    logic                csn_prev_reg;
    logic                csn_fall;
    logic                wr_fire;
    logic                rd_start;
    logic                rd_pend;
    logic                rd_load;
    logic [1:0]          rd_addr_reg;
    logic [RD_LAT-2:0]   rd_sr_reg;
    logic                rd_valid_reg;
    logic [DATA_W-1:0]   datout_reg;
    logic [DATA_W-1:0]   rd_mux;

    // Registers
    logic                enable_reg;
    logic                sticky_reg;
    logic [7:0]          spur_cnt_reg;
    logic                flush;
    logic                spur_clr;
    logic                spur_hit;

    // Acknowledge FSM
    ack_st_e             state_reg;
    ack_st_e             state_next;
    logic [LEN_W-1:0]    len_cnt_reg;
    logic [GAP_W-1:0]    gap_cnt_reg;
    logic                inta_n_reg;
    logic                first_ack;

    // FIFO
    logic                fifo_push;
    logic                fifo_pop;
    logic [CODE_W:0]     fifo_rd_data;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    logic                unused_datin;
    assign unused_datin = ^bus.i_datin_50m[DATA_W-1:2];

    assign csn_fall  = csn_prev_reg & ~bus.i_csn_50m;
    assign wr_fire   = csn_fall & bus.i_wr_50m;
    assign rd_pend   = |rd_sr_reg;
    assign rd_start  = csn_fall & bus.i_rd_50m & ~bus.i_wr_50m & ~rd_pend;
    // Last stage of the latency pipe: data is captured so it appears with rd_valid
    assign rd_load   = rd_sr_reg[RD_LAT-2];

    assign flush     = wr_fire & (bus.i_addr_50m == ADDR_CTRL) & bus.i_datin_50m[1];
    assign spur_clr  = wr_fire & (bus.i_addr_50m == ADDR_SPUR);

    assign first_ack = (state_reg == ACK) && (len_cnt_reg == '0);
    assign fifo_push = first_ack & INTR;
    assign spur_hit  = first_ack & ~INTR;
    assign fifo_pop  = rd_load & (rd_addr_reg == ADDR_CODE);

    gpio_int_code_fifo #(
        .WIDTH (CODE_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_50m),
        .rst_n   (rstn_50m),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (flush),
        .wr_data ({1'b1, INT_CODE}),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        rd_mux = '0;
        case (rd_addr_reg)
            ADDR_CTRL: rd_mux[0] = enable_reg;
            ADDR_STATUS: begin
                rd_mux[0]         = fifo_empty;
                rd_mux[1]         = fifo_full;
                rd_mux[2]         = sticky_reg;
                rd_mux[CNT_W+3:4] = fifo_count;
            end
            ADDR_CODE: begin
                if (!fifo_empty) rd_mux[CODE_W:0] = fifo_rd_data;
            end
            default: rd_mux[7:0] = spur_cnt_reg;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rstn_50m) begin
        if (!rstn_50m) begin
            csn_prev_reg <= 1'b1;
            rd_addr_reg  <= '0;
            rd_sr_reg    <= '0;
            rd_valid_reg <= 1'b0;
            datout_reg   <= '0;
        end else begin
            csn_prev_reg <= bus.i_csn_50m;
            if (rd_start) rd_addr_reg <= bus.i_addr_50m;
            rd_sr_reg    <= {rd_sr_reg[RD_LAT-3:0], rd_start};
            rd_valid_reg <= rd_load;
            if (rd_load) datout_reg <= rd_mux;
        end
    end

    always_ff @(posedge clk_50m or negedge rstn_50m) begin
        if (!rstn_50m) begin
            enable_reg   <= 1'b0;
            sticky_reg   <= 1'b0;
            spur_cnt_reg <= '0;
        end else begin
            if (wr_fire && bus.i_addr_50m == ADDR_CTRL) enable_reg <= bus.i_datin_50m[0];
            // A software clear wins over a spurious event in the same cycle
            if (spur_clr) begin
                sticky_reg   <= 1'b0;
                spur_cnt_reg <= '0;
            end else if (spur_hit) begin
                sticky_reg   <= 1'b1;
                spur_cnt_reg <= sat_inc8(spur_cnt_reg);
            end
        end
    end

    // Disable only gates the IDLE exit; an ongoing handshake always completes
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable_reg && INTR && !fifo_full) state_next = ACK;
            ACK:     if (len_cnt_reg == LEN_W'(INTA_LEN - 1)) state_next = RECOV;
            RECOV:   if (gap_cnt_reg == GAP_W'(GAP - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rstn_50m) begin
        if (!rstn_50m) begin
            state_reg   <= IDLE;
            len_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            inta_n_reg  <= 1'b1;
        end else begin
            state_reg   <= state_next;
            len_cnt_reg <= (state_reg == ACK && state_next == ACK) ? len_cnt_reg + LEN_W'(1) : '0;
            gap_cnt_reg <= (state_reg == RECOV && state_next == RECOV) ? gap_cnt_reg + GAP_W'(1) : '0;
            inta_n_reg  <= (state_next != ACK);
        end
    end

    assign INTA_N           = inta_n_reg;
    assign o_irq_cpu        = enable_reg & ~fifo_empty;
    assign bus.wr_valid     = wr_fire;
    assign bus.rd_valid     = rd_valid_reg;
    assign bus.o_datout_50m = datout_reg;

endmodule

// File: tb/tb_gpio_int_ack_ctrl.sv
// Randomized and directed checks of gpio_int_ack_ctrl against a cycle-timeline
// model (code queue, acknowledge windows, pending-read timestamps).
module tb_gpio_int_ack_ctrl;

    localparam int CODE_W   = 3;
    localparam int DATA_W   = 16;
    localparam int DEPTH    = 8;
    localparam int INTA_LEN = 2;
    localparam int GAP      = 2;
    localparam int LAT      = 7;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              intr = 1'b0;
    logic [CODE_W-1:0] code = '0;
    logic              inta_n;
    logic              irq;

    gpio_int_ack_ctrl_if #(.DATA_W(DATA_W)) bus_if ();

    gpio_int_ack_ctrl #(
        .CODE_W(CODE_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .INTA_LEN(INTA_LEN), .GAP(GAP)
    ) dut (
        .clk_50m   (clk),
        .rstn_50m  (rstn),
        .INTR      (intr),
        .INT_CODE  (code),
        .INTA_N    (inta_n),
        .bus       (bus_if.slave),
        .o_irq_cpu (irq)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n = 0;
    logic [DATA_W-1:0] last_rd = '0;

    // Model state: timeline of acknowledges and reads, queue of captured codes
    int  m_q[$];
    bit  m_en, m_sticky, m_csn_prev;
    int  m_spur, m_ack_first, m_free_at, m_rd_start, m_raddr, m_dat;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h cycle=%0d", tag, got, exp, n);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_en = 0; m_sticky = 0; m_csn_prev = 1; m_spur = 0;
        m_ack_first = -100; m_free_at = 0; m_rd_start = -100; m_raddr = 0; m_dat = 0;
    endfunction

    function automatic void model_step();
        bit fall, wf, rf, flush, load, do_pop, push, spur_hit;
        int nd;
        fall     = m_csn_prev && !bus_if.i_csn_50m;
        wf       = fall && bus_if.i_wr_50m;
        rf       = fall && bus_if.i_rd_50m && !bus_if.i_wr_50m && !(n > m_rd_start && n < m_rd_start + LAT);
        flush    = wf && bus_if.i_addr_50m == 2'd0 && bus_if.i_datin_50m[1];
        load     = (n == m_rd_start + LAT - 1);
        do_pop   = 0;
        push     = (n == m_ack_first) && intr;
        spur_hit = (n == m_ack_first) && !intr;
        nd       = m_dat;
        if (load) begin
            case (m_raddr)
                0: nd = m_en;
                1: nd = (m_q.size() == 0 ? 1 : 0) + (m_q.size() == DEPTH ? 2 : 0)
                        + (m_sticky ? 4 : 0) + m_q.size() * 16;
                2: if (m_q.size() != 0) begin nd = (1 << CODE_W) + m_q[0]; do_pop = 1; end
                   else nd = 0;
                default: nd = m_spur;
            endcase
        end
        if (n >= m_free_at && m_en && intr && m_q.size() < DEPTH) begin
            m_ack_first = n + 1;
            m_free_at   = n + 1 + INTA_LEN + GAP;
        end
        if (flush) m_q.delete();
        else begin
            if (do_pop) void'(m_q.pop_front());
            if (push) m_q.push_back(int'(code));
        end
        if (wf && bus_if.i_addr_50m == 2'd3) begin m_spur = 0; m_sticky = 0; end
        else if (spur_hit) begin m_spur = (m_spur < 255) ? m_spur + 1 : 255; m_sticky = 1; end
        if (wf && bus_if.i_addr_50m == 2'd0) m_en = bus_if.i_datin_50m[0];
        if (rf) begin m_rd_start = n; m_raddr = int'(bus_if.i_addr_50m); end
        if (load) m_dat = nd;
        m_csn_prev = bus_if.i_csn_50m;
    endfunction

    task automatic cycle();
        @(negedge clk);
        check_val("inta_n",   inta_n, (n >= m_ack_first && n < m_ack_first + INTA_LEN) ? 0 : 1);
        check_val("irq",      irq, (m_en && m_q.size() != 0) ? 1 : 0);
        check_val("wr_valid", bus_if.wr_valid, (m_csn_prev && !bus_if.i_csn_50m && bus_if.i_wr_50m) ? 1 : 0);
        check_val("rd_valid", bus_if.rd_valid, (n == m_rd_start + LAT) ? 1 : 0);
        check_val("datout",   bus_if.o_datout_50m, m_dat);
        if (bus_if.rd_valid) last_rd = bus_if.o_datout_50m;
        model_step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [DATA_W-1:0] d);
        bus_if.i_csn_50m = 0; bus_if.i_wr_50m = 1; bus_if.i_addr_50m = a; bus_if.i_datin_50m = d;
        cycle();
        bus_if.i_csn_50m = 1; bus_if.i_wr_50m = 0;
        cycle();
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [DATA_W-1:0] d);
        bus_if.i_csn_50m = 0; bus_if.i_rd_50m = 1; bus_if.i_addr_50m = a;
        cycle();
        bus_if.i_csn_50m = 1; bus_if.i_rd_50m = 0;
        repeat (LAT) cycle();
        d = last_rd;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && n < m_free_at; k++) cycle();
    endtask

    task automatic spur_pulse();
        wait_idle();
        intr = 1; cycle();
        intr = 0; cycle();
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        int t0, k;
        bit hit;
        bus_if.i_csn_50m = 1; bus_if.i_wr_50m = 0; bus_if.i_rd_50m = 0;
        bus_if.i_addr_50m = '0; bus_if.i_datin_50m = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1;
        @(posedge clk); #1;

        check_val("rst_inta_n", inta_n, 1);
        check_val("rst_irq", irq, 0);
        check_val("rst_datout", bus_if.o_datout_50m, 0);

        // Single interrupt, code 5
        bus_wr(2'd0, 16'h0001);
        intr = 1; code = 3'd5;
        for (k = 0; k < 20 && n != m_ack_first; k++) cycle();
        cycle();
        intr = 0;
        repeat (4) cycle();
        check_val("irq_held", irq, 1);
        bus_rd(2'd2, d);
        check_val("code5", d, 16'h000D);
        check_val("irq_after_pop", irq, 0);

        // Fill the FIFO back to back; the ninth request waits for a pop
        intr = 1;
        repeat (60) begin code = 3'($urandom); cycle(); end
        bus_rd(2'd1, d);
        check_val("status_full", d, 16'h0082);
        repeat (10) cycle();
        bus_rd(2'd2, d);
        check_val("ack_after_pop", inta_n, 0);
        repeat (6) cycle();

        // Flush with three entries held and a push landing in the same cycle
        bus_wr(2'd0, 16'h0003);
        hit = 0;
        for (k = 0; k < 200; k++) begin
            if (m_q.size() == 3 && n == m_ack_first) begin hit = 1; break; end
            code = 3'($urandom); cycle();
        end
        check_val("flush_sync_reached", hit, 1);
        bus_if.i_csn_50m = 0; bus_if.i_wr_50m = 1; bus_if.i_addr_50m = 2'd0; bus_if.i_datin_50m = 16'h0003;
        cycle();
        bus_if.i_csn_50m = 1; bus_if.i_wr_50m = 0; intr = 0;
        repeat (6) cycle();
        bus_rd(2'd1, d);
        check_val("status_flushed", d, 16'h0001);
        check_val("irq_flushed", irq, 0);

        // Spurious acknowledge
        spur_pulse();
        repeat (4) cycle();
        bus_rd(2'd3, d);
        check_val("spur_one", d, 16'h0001);
        bus_rd(2'd1, d);
        check_val("status_sticky", d, 16'h0005);
        bus_wr(2'd3, 16'h0000);
        bus_rd(2'd3, d);
        check_val("spur_cleared", d, 16'h0000);
        bus_rd(2'd1, d);
        check_val("sticky_cleared", d, 16'h0001);

        // Two entries, then a CODE pop aligned with the first ACK cycle of a push
        intr = 1; code = 3'd6;
        for (k = 0; k < 40 && m_q.size() < 2; k++) cycle();
        intr = 0;
        wait_idle();
        repeat (2) cycle();
        t0 = n;
        bus_if.i_csn_50m = 0; bus_if.i_rd_50m = 1; bus_if.i_addr_50m = 2'd2;
        cycle();
        bus_if.i_csn_50m = 1; bus_if.i_rd_50m = 0;
        while (n < t0 + 5) cycle();
        intr = 1; code = 3'd2;
        cycle(); cycle();
        intr = 0;
        repeat (6) cycle();
        bus_rd(2'd1, d);
        check_val("pushpop_count", d, 16'h0020);

        // Spurious counter saturation
        for (int i = 0; i < 258; i++) spur_pulse();
        repeat (4) cycle();
        bus_rd(2'd3, d);
        check_val("spur_saturate", d, 16'h00FF);
        bus_wr(2'd3, 16'h0000);

        // Asynchronous reset in the middle of an acknowledge
        intr = 1;
        for (k = 0; k < 40 && !(n >= m_ack_first && n < m_ack_first + INTA_LEN); k++) cycle();
        check_val("inta_low_before_rst", inta_n, 0);
        rstn = 0;
        #2;
        check_val("async_inta_n", inta_n, 1);
        check_val("async_irq", irq, 0);
        check_val("async_datout", bus_if.o_datout_50m, 0);
        check_val("async_rd_valid", bus_if.rd_valid, 0);
        intr = 0;
        @(posedge clk); @(posedge clk);
        @(negedge clk) rstn = 1;
        @(posedge clk); #1;
        n++;
        model_reset();
        bus_rd(2'd1, d);
        check_val("status_after_rst", d, 16'h0001);
        bus_wr(2'd0, 16'h0001);
        intr = 1; code = 3'd3;
        for (k = 0; k < 20 && n != m_ack_first; k++) cycle();
        cycle();
        intr = 0;
        repeat (4) cycle();
        bus_rd(2'd1, d);
        check_val("status_after_rst_ack", d, 16'h0010);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            if ($urandom_range(0, 3) == 0) intr = ~intr;
            if ($urandom_range(0, 2) == 0) code = 3'($urandom);
            r = $urandom_range(0, 15);
            if (bus_if.i_csn_50m == 0) begin
                bus_if.i_csn_50m = 1; bus_if.i_wr_50m = 0; bus_if.i_rd_50m = 0;
            end else if (r < 6) begin
                bus_if.i_csn_50m = 0; bus_if.i_rd_50m = 1;
                bus_if.i_addr_50m = (r < 4) ? 2'd2 : 2'($urandom);
            end else if (r == 6) begin
                bus_if.i_csn_50m = 0; bus_if.i_wr_50m = 1; bus_if.i_addr_50m = 2'd0;
                bus_if.i_datin_50m = DATA_W'($urandom);
                bus_if.i_datin_50m[0] = ($urandom_range(0, 7) != 0);
                bus_if.i_datin_50m[1] = ($urandom_range(0, 3) == 0);
            end else if (r == 7) begin
                bus_if.i_csn_50m = 0; bus_if.i_wr_50m = 1; bus_if.i_addr_50m = 2'($urandom);
                bus_if.i_datin_50m = DATA_W'($urandom);
                bus_if.i_datin_50m[0] = 1'b1;
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
